// File: rtl/text_overlay.sv
// Character-buffer text overlay: host-written COLS x ROWS code screen, font pel lookup, delayed syncs.
// Optional blinking cursor cell enabled by defining TEXT_OVERLAY_CURSOR_EN.
module text_overlay #(
  parameter int COLS     = 80,
  parameter int ROWS     = 30,
  parameter int SYNC_DLY = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   char_x,
  input  logic [7:0]   char_y,
  input  logic [255:0] ascii_char,
  input  logic         blank,
  input  logic         hsync,
  input  logic         vsync,
  input  logic         wr_valid,
  input  logic [7:0]   wr_data,
  output logic         wr_ready,
  output logic         pix,
  output logic         blank_out,
  output logic         hsync_out,
  output logic         vsync_out,
  output logic         dbg_state_o
);
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_e;

  state_e        state_q;
  logic [AW-1:0] clr_addr_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          wr_ready_q;

  logic [7:0]    mem [CELLS];
  logic          we;
  logic [AW-1:0] wa;
  logic [7:0]    wd;
  logic [AW-1:0] cur_addr;
  logic [RW-1:0] row_adv;
  logic          accept;
  logic          printable;

  // Handshake: a byte moves on any clock edge where wr_valid && wr_ready; wr_ready is high only in IDLE.
  assign accept    = wr_ready_q && wr_valid;
  assign printable = (wr_data >= 8'h20) && (wr_data <= 8'h7E);
  assign cur_addr  = AW'(row_q) * AW'(COLS) + AW'(col_q);
  assign row_adv   = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;

  always_comb begin
    we = 1'b0;
    wa = cur_addr;
    wd = wr_data;
    if (state_q == S_CLEAR) begin
      we = 1'b1;
      wa = clr_addr_q;
      wd = 8'h20;
    end else if (accept && printable) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr_addr_q == LAST_ADDR) begin
            state_q    <= S_IDLE;
            wr_ready_q <= 1'b1;
            col_q      <= '0;
            row_q      <= '0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            if (printable) begin
              if (col_q == LAST_COL) begin
                col_q <= '0;
                row_q <= row_adv;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end else begin
              case (wr_data)
                8'h0D: col_q <= '0;
                8'h0A: row_q <= row_adv;
                8'h08: if (col_q != '0) col_q <= col_q - 1'b1;
                8'h0C: begin
                  state_q    <= S_CLEAR;
                  wr_ready_q <= 1'b0;
                  clr_addr_q <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign wr_ready    = wr_ready_q;
  assign dbg_state_o = state_q;

  // Video read port: registered read gives old data on a same-address write (read-first).
  logic          on_screen;
  logic [AW-1:0] rd_addr;
  logic [7:0]    code_q;
  logic          offs_q;
  logic          pix_q;
  logic          invert;

  assign on_screen = (int'(char_x) < COLS) && (int'(char_y) < ROWS);
  assign rd_addr   = on_screen ? (AW'(char_y) * AW'(COLS) + AW'(char_x)) : '0;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    code_q <= mem[rd_addr];
  end

`ifdef TEXT_OVERLAY_CURSOR_EN
  logic [5:0] frame_q;
  logic       vsync_q;
  logic       cur_hit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q   <= '0;
      vsync_q   <= 1'b0;
      cur_hit_q <= 1'b0;
    end else begin
      vsync_q   <= vsync;
      if (vsync && !vsync_q) frame_q <= frame_q + 1'b1;
      cur_hit_q <= (char_x == 8'(col_q)) && (char_y == 8'(row_q));
    end
  end

  assign invert = frame_q[5] && cur_hit_q;
`else
  assign invert = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      offs_q <= 1'b1;
      pix_q  <= 1'b0;
    end else begin
      offs_q <= !on_screen;
      pix_q  <= offs_q ? 1'b0 : (ascii_char[code_q] ^ invert);
    end
  end

  assign pix = pix_q;

  logic [SYNC_DLY-1:0] blank_sr_q;
  logic [SYNC_DLY-1:0] hsync_sr_q;
  logic [SYNC_DLY-1:0] vsync_sr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_sr_q <= '1;
      hsync_sr_q <= '0;
      vsync_sr_q <= '0;
    end else begin
      blank_sr_q <= (blank_sr_q << 1) | SYNC_DLY'(blank);
      hsync_sr_q <= (hsync_sr_q << 1) | SYNC_DLY'(hsync);
      vsync_sr_q <= (vsync_sr_q << 1) | SYNC_DLY'(vsync);
    end
  end

  assign blank_out = blank_sr_q[SYNC_DLY-1];
  assign hsync_out = hsync_sr_q[SYNC_DLY-1];
  assign vsync_out = vsync_sr_q[SYNC_DLY-1];
endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: clear timing, host cursor rules, video lookup, off-screen, sync delay.
module tb_text_overlay;
  logic         clk;
  logic         reset;
  logic [7:0]   char_x;
  logic [7:0]   char_y;
  logic [255:0] ascii_char;
  logic         blank;
  logic         hsync;
  logic         vsync;
  logic         wr_valid;
  logic [7:0]   wr_data;
  logic         wr_ready;
  logic         pix;
  logic         blank_out;
  logic         hsync_out;
  logic         vsync_out;
  logic         dbg_state_o;

  int n_cmp;
  int n_fail;

  text_overlay dut (
    .clk(clk), .reset(reset), .char_x(char_x), .char_y(char_y),
    .ascii_char(ascii_char), .blank(blank), .hsync(hsync), .vsync(vsync),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .pix(pix),
    .blank_out(blank_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .dbg_state_o(dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    while (!wr_ready && w < 5000) begin
      tick();
      w++;
    end
    if (!wr_ready) chk("send_timeout", 32'(w), 32'd0);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic send_rep(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b);
  endtask

  // Present a cell with only the pel bit of one code set; pix is 1 iff the cell holds that code.
  task automatic read_pix(input int x, input int y, input logic [7:0] code, output logic p);
    char_x = 8'(x);
    char_y = 8'(y);
    ascii_char = '0;
    ascii_char[code] = 1'b1;
    tick();
    tick();
    p = pix;
  endtask

  task automatic check_cell(input string tag, input int x, input int y, input logic [7:0] code,
                            input logic exp);
    logic p;
    read_pix(x, y, code, p);
    chk(tag, 32'(p), 32'(exp));
  endtask

  task automatic check_all_ones(input string tag, input int x, input int y, input logic exp);
    char_x = 8'(x);
    char_y = 8'(y);
    ascii_char = '1;
    tick();
    tick();
    chk(tag, 32'(pix), 32'(exp));
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (!wr_ready && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic vsync_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
    end
  endtask

  initial begin
    int   nlow;
    int   hits;
    logic p;
    logic [39:0] pb;
    logic [39:0] ph;
    logic [39:0] pv;
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    char_x = '0;
    char_y = '0;
    ascii_char = '0;
    blank = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'h00;

    // Reset values with the timing inputs held opposite to their reset values.
    repeat (3) tick();
    chk("rst_pix", 32'(pix), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_blank_out", 32'(blank_out), 32'd1);
    chk("rst_hsync_out", 32'(hsync_out), 32'd0);
    chk("rst_vsync_out", 32'(vsync_out), 32'd0);
    chk("rst_state_clear", 32'(dbg_state_o), 32'd0);
    blank = 1'b1;
    hsync = 1'b0;
    vsync = 1'b0;
    tick();
    reset = 1'b0;

    count_low(nlow);
    wr_valid = 1'b0;
    chk("init_clear_len", 32'(nlow), 32'd2400);
    chk("init_state_idle", 32'(dbg_state_o), 32'd1);

    hits = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) begin
        read_pix(c, r, 8'h20, p);
        if (p) hits++;
      end
    chk("clear_all_spaces", 32'(hits), 32'd2400);

    send_byte(8'h41);
    send_byte(8'h42);
    check_cell("A_at_0_0", 0, 0, 8'h41, 1'b1);
    check_cell("B_at_1_0", 1, 0, 8'h42, 1'b1);
    check_cell("B_not_A", 1, 0, 8'h41, 1'b0);
    check_cell("cell_2_0_space", 2, 0, 8'h20, 1'b1);

    // Row wrap: 80 bytes fill row 0, the next lands at (0,1).
    send_byte(8'h0D);
    for (int i = 0; i < 80; i++) send_byte(8'(8'h61 + (i % 26)));
    send_byte(8'h5A);
    check_cell("Z_at_0_1", 0, 1, 8'h5A, 1'b1);
    check_cell("row0_col79", 79, 0, 8'h62, 1'b1);
    check_cell("row0_col0", 0, 0, 8'h61, 1'b1);
    check_cell("row0_col2", 2, 0, 8'h63, 1'b1);

    // Cursor (1,1) -> (0,29) -> (79,29); one more byte wraps the screen to (0,0).
    send_rep(8'h0A, 28);
    send_byte(8'h08);
    send_rep(8'h78, 79);
    send_byte(8'h51);
    send_byte(8'h52);
    check_cell("row29_col78", 78, 29, 8'h78, 1'b1);
    check_cell("Q_at_79_29", 79, 29, 8'h51, 1'b1);
    check_cell("R_wrap_0_0", 0, 0, 8'h52, 1'b1);
    check_cell("Z_kept_0_1", 0, 1, 8'h5A, 1'b1);

    // Control codes from (0,5); 0x00 and 0x7F must neither write nor move.
    send_byte(8'h0D);
    send_rep(8'h0A, 5);
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h7F);
    send_byte(8'h4B);
    check_cell("K_at_0_6", 0, 6, 8'h4B, 1'b1);
    check_cell("cell_1_6_space", 1, 6, 8'h20, 1'b1);
    check_cell("cell_0_5_space", 0, 5, 8'h20, 1'b1);
    send_byte(8'h08);
    send_byte(8'h4C);
    check_cell("L_over_0_6", 0, 6, 8'h4C, 1'b1);
    check_cell("cell_1_6_still", 1, 6, 8'h20, 1'b1);

    check_all_ones("offscreen_x80", 80, 0, 1'b0);
    check_all_ones("offscreen_y30", 0, 30, 1'b0);
    check_all_ones("offscreen_ff", 255, 255, 1'b0);
    check_all_ones("onscreen_corner", 79, 29, 1'b1);

    send_byte(8'h0C);
    chk("ff_ready_low", 32'(wr_ready), 32'd0);
    count_low(nlow);
    chk("ff_clear_len", 32'(nlow), 32'd2400);
    send_byte(8'h4D);
    check_cell("M_home_0_0", 0, 0, 8'h4D, 1'b1);
    check_cell("ff_cleared_79_29", 79, 29, 8'h20, 1'b1);
    check_cell("ff_cleared_0_6", 0, 6, 8'h20, 1'b1);

    // Reset part-way through a clear restarts it from address 0.
    send_byte(8'h0C);
    repeat (500) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_low(nlow);
    chk("rst_mid_clear_len", 32'(nlow), 32'd2400);
    check_cell("rst_cleared_0_0", 0, 0, 8'h20, 1'b1);

`ifdef TEXT_OVERLAY_CURSOR_EN
    send_byte(8'h43);
    vsync_pulses(32);
    check_cell("cursor_inverted", 1, 0, 8'h20, 1'b0);
    check_cell("noncursor_plain", 0, 0, 8'h43, 1'b1);
    check_all_ones("cursor_offscreen", 80, 0, 1'b0);
    vsync_pulses(32);
    check_cell("cursor_not_inv", 1, 0, 8'h20, 1'b1);
`endif

    pb = 40'hA53C96E10F;
    ph = 40'h5AC3691EF0;
    pv = 40'h33CC55AA17;
    for (int j = 0; j < 40; j++) begin
      if (j >= 3) begin
        chk("blank_dly", 32'(blank_out), 32'(pb[j-3]));
        chk("hsync_dly", 32'(hsync_out), 32'(ph[j-3]));
        chk("vsync_dly", 32'(vsync_out), 32'(pv[j-3]));
      end
      blank = pb[j];
      hsync = ph[j];
      vsync = pv[j];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
